// File: rtl/edge_defs_pkg.sv
// Shared definitions for the multi-channel edge detector: per-channel mode
// encodings and the helper that gates raw edges by mode.
package edge_defs;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  function automatic logic gate_edge(input edge_mode_e m, input logic pe, input logic ne);
    logic hit;
    case (m)
      EDGE_OFF:  hit = 1'b0;
      EDGE_RISE: hit = pe;
      EDGE_FALL: hit = ne;
      EDGE_BOTH: hit = pe | ne;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser chain, stable-count debounce filter, previous-level
// register and mode-independent rising/falling edge pulses.
module edge_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cp,
  output logic level,
  output logic p_edge,
  output logic n_edge
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] CNT_ZERO = DB_W'(0);
  localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sout_s;
  logic [DB_W-1:0]        cnt_r;
  logic [DB_W-1:0]        cnt_nxt_s;
  logic                   level_r;
  logic                   level_nxt_s;
  logic                   prev_r;

  assign sout_s = sync_r[SYNC_STAGES-1];

  // Synchroniser shift chain fed by the raw asynchronous input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r[0] <= cp;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Debounce: level only follows sout after DB_CYCLES consecutive mismatches;
  // any return to agreement restarts the count.
  always_comb begin
    level_nxt_s = level_r;
    cnt_nxt_s   = CNT_ZERO;
    if (sout_s == level_r) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r == DB_LAST) begin
      level_nxt_s = sout_s;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Filtered level, debounce counter and previous-level registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
      prev_r  <= 1'b0;
    end else begin
      level_r <= level_nxt_s;
      cnt_r   <= cnt_nxt_s;
      prev_r  <= level_r;
    end
  end

  assign level  = level_r;
  assign p_edge = level_r & ~prev_r;
  assign n_edge = ~level_r & prev_r;

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: CH independent channels with per-channel mode
// gating, sticky event flags with synchronous clear and an OR summary.
module edge_detector_multi
  import edge_defs::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CH-1:0] cp,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0] clr,
  output logic [CH-1:0] level,
  output logic [CH-1:0] p_edge,
  output logic [CH-1:0] n_edge,
  output logic [CH-1:0] evt_pulse,
  output logic [CH-1:0] evt_flag,
  output logic          any_evt
);

  logic [CH-1:0] flag_r;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .cp     (cp[g]),
      .level  (level[g]),
      .p_edge (p_edge[g]),
      .n_edge (n_edge[g])
    );
  end

  // Mode gating is combinational so a mode change takes effect immediately.
  always_comb begin
    evt_pulse = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      evt_pulse[i] = gate_edge(edge_mode_e'(mode[2*i +: 2]), p_edge[i], n_edge[i]);
    end
  end

  // Sticky flags: a new event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_r <= {CH{1'b0}};
    end else begin
      flag_r <= evt_pulse | (flag_r & ~clr);
    end
  end

  assign evt_flag = flag_r;
  assign any_evt  = |flag_r;

endmodule
